// File: rtl/fpu_add_sub_norm_round.sv
// Post-ALU normalize/round stage of the FPU adder: 2-stage valid/ready pipeline packing IEEE-754 single.
// Define FPU_NORM_ROUND_EN for round-to-nearest-even; otherwise the result is truncated.
module fpu_add_sub_norm_round #(
   parameter int unsigned SIZE_MAN = 24,
   parameter int unsigned SIZE_EXP = 8
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_valid,
   output logic                         o_ready,
   input  logic                         i_sign,
   input  logic [SIZE_EXP-1:0]          i_exp_max,
   input  logic [SIZE_MAN-1:0]          i_man_alu,
   input  logic                         i_overflow,
   input  logic [2:0]                   i_grs,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic [SIZE_EXP+SIZE_MAN-1:0] o_result,
   output logic                         o_of,
   output logic                         o_uf
);
   localparam int unsigned WW  = SIZE_MAN + 3;
   localparam int unsigned LZW = $clog2(WW);
   localparam int unsigned EW  = SIZE_EXP + 2;
   localparam logic signed [EW-1:0] E_INF  = {2'b00, {SIZE_EXP{1'b1}}};
   localparam logic signed [EW-1:0] E_ZERO = '0;

   logic                  v_n, v_r, ready_n, ready_r;
   logic [WW-1:0]         w_raw, w_shift, w_n;
   logic signed [EW-1:0]  e_raw, e_n, e_r;
   logic                  z_raw, z_n, s_n;
   logic [LZW-1:0]        lz;
   logic [SIZE_MAN-2:0]   frac_r;
   logic [SIZE_EXP+SIZE_MAN-1:0] res_c;
   logic                  of_c, uf_c;

   assign ready_r = ~v_r | i_ready;
   assign ready_n = ~v_n | ready_r;
   assign o_ready = ready_n;
   assign o_valid = v_r;

   // Carry-out case: the right shift by one folds r and s into a single sticky bit.
   always_comb begin
      w_raw = i_overflow ? {1'b1, i_man_alu, i_grs[2], i_grs[1] | i_grs[0]}
                         : {i_man_alu, i_grs};
      z_raw = ~i_overflow & ~(|{i_man_alu, i_grs});
      lz = '0;
      for (int unsigned i = 0; i < WW; i++) begin
         if (w_raw[i]) lz = LZW'(WW - 1 - i);
      end
      w_shift = w_raw << lz;
      if (i_overflow) e_raw = EW'({2'b00, i_exp_max}) + EW'(1);
      else            e_raw = EW'({2'b00, i_exp_max}) - EW'(lz);
   end

`ifdef FPU_NORM_ROUND_EN
   logic              round_up;
   logic [SIZE_MAN:0] man_sum;
   logic              unused_bits;

   always_comb begin
      round_up = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
      man_sum  = {1'b0, w_n[WW-1:3]} + {{SIZE_MAN{1'b0}}, round_up};
      if (man_sum[SIZE_MAN]) begin
         frac_r = '0;
         e_r    = e_n + EW'(1);
      end else begin
         frac_r = man_sum[SIZE_MAN-2:0];
         e_r    = e_n;
      end
   end
   assign unused_bits = man_sum[SIZE_MAN-1];
`else
   logic unused_bits;

   always_comb begin
      frac_r = w_n[WW-2:3];
      e_r    = e_n;
   end
   assign unused_bits = ^{w_n[WW-1], w_n[2:0]};
`endif

   always_comb begin
      res_c = '0;
      of_c  = 1'b0;
      uf_c  = 1'b0;
      if (z_n) begin
         res_c = '0;
      end else if (e_r >= E_INF) begin
         res_c = {s_n, {SIZE_EXP{1'b1}}, {(SIZE_MAN-1){1'b0}}};
         of_c  = 1'b1;
      end else if (e_r <= E_ZERO) begin
         res_c = {s_n, {(SIZE_EXP+SIZE_MAN-1){1'b0}}};
         uf_c  = 1'b1;
      end else begin
         res_c = {s_n, e_r[SIZE_EXP-1:0], frac_r};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         v_n      <= 1'b0;
         v_r      <= 1'b0;
         w_n      <= '0;
         e_n      <= '0;
         z_n      <= 1'b0;
         s_n      <= 1'b0;
         o_result <= '0;
         o_of     <= 1'b0;
         o_uf     <= 1'b0;
      end else begin
         if (ready_n) begin
            v_n <= i_valid;
            if (i_valid) begin
               w_n <= w_shift;
               e_n <= e_raw;
               z_n <= z_raw;
               s_n <= i_sign & ~z_raw;
            end
         end
         if (ready_r) begin
            v_r <= v_n;
            if (v_n) begin
               o_result <= res_c;
               o_of     <= of_c;
               o_uf     <= uf_c;
            end
         end
      end
   end
endmodule
